// File: rtl/merge_ctrl_axil_slave.sv
// AXI4-Lite register slave for the merge core: four 32-bit read/write
// registers at byte offsets 0x0, 0x4, 0x8 and 0xC. The outputs reg0_o..reg3_o
// show the live register contents.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  - clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*       - write address and write data channels,
//                                each accepted independently
//   S_AXI_B*                   - write response channel
//   S_AXI_AR* / S_AXI_R*       - read address and read data channels
//   reg0_o..reg3_o             - register contents
//
// Configuration macro MERGE_AXIL_SLVERR_EN: when it is defined, accesses to
// the unmapped indices 4..15 return SLVERR. When it is not defined they
// return OKAY. In both cases reads of those indices return 0 and writes to
// them are dropped.
//
// Write FSM:  W_IDLE | gathering AW and W into holding registers
//             W_RESP | register updated, BVALID high until BREADY
// Read FSM:   R_IDLE | waiting for AR
//             R_DATA | RDATA/RRESP registered, RVALID high until RREADY
module merge_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef MERGE_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic                rdy_en_q;
  logic                aw_held_q, aw_held_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic                w_held_q, w_held_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [DW-1:0]       regs_q [4];
  logic [DW-1:0]       regs_d [4];

  logic                aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [DW-1:0]       wr_data;
  logic [STRB_W-1:0]   wr_strb;

  // Only indices 0..3 are backed by registers.
  function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
    return (idx >> 2) == '0;
  endfunction

  // The READY outputs are gated by a flop that reset clears. This keeps them
  // low while reset is asserted and makes them rise at the first edge after
  // reset is released.
  assign S_AXI_AWREADY = rdy_en_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = rdy_en_q && (w_state_q == W_IDLE) && !w_held_q;
  assign S_AXI_ARREADY = rdy_en_q && (r_state_q == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Address and data go around the holding registers in the cycle of their
  // handshake. This lets a same-edge AW/W pair commit without waiting a cycle.
  assign wr_idx  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (is_mapped(wr_idx)) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) regs_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_UNMAPPED;
          end
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  // Reads sample regs_q before the edge. A read that hits the same edge as a
  // write to the same register therefore returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          if (is_mapped(rd_idx)) begin
            rdata_d = regs_q[rd_idx[1:0]];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_UNMAPPED;
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_en_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];

  // PROT and the byte-lane address bits have no function in this slave.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_merge_ctrl_axil_slave.sv
module tb_merge_ctrl_axil_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, reg0, reg1, reg2, reg3;

  always #5 clk = ~clk;

  merge_ctrl_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3)
  );

`ifdef MERGE_AXIL_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  logic [31:0] model [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr[5:2] < 4) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
      exp_b_q.push_back(2'b00);
    end else begin
      exp_b_q.push_back(UNMAP_RESP);
    end
  endtask

  task automatic model_read(input logic [5:0] addr);
    if (addr[5:2] < 4) exp_r_q.push_back({2'b00, model[addr[3:2]]});
    else               exp_r_q.push_back({UNMAP_RESP, 32'h0});
  endtask

  // Drives AW and W together and returns once both handshakes are done. The
  // response is collected separately by wait_b.
  task automatic issue_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_done, w_done, aw_r, w_r;
    model_write(addr, data, strb);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      aw_r = awready && awvalid;
      w_r  = wready && wvalid;
      tick();
      if (aw_r) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_r)  begin w_done = 1'b1;  wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
  endtask

  task automatic wait_b();
    logic seen;
    logic [1:0] e;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (bvalid) seen = 1'b1;
      else tick();
    end
    check("bvalid_seen", seen, 1'b1);
    if (seen) begin
      e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'bxx;
      check("bresp", bresp, e);
      bready = 1'b1;
      tick();
      bready = 1'b0;
    end
  endtask

  task automatic issue_read(input logic [5:0] addr);
    logic done, r;
    model_read(addr);
    araddr = addr; arvalid = 1'b1; done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      r = arready;
      tick();
      if (r) done = 1'b1;
    end
    arvalid = 1'b0;
    check("rd_accept", done, 1'b1);
  endtask

  task automatic wait_r(input string tag);
    logic seen;
    logic [33:0] e;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (rvalid) seen = 1'b1;
      else tick();
    end
    check("rvalid_seen", seen, 1'b1);
    if (seen) begin
      e = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : 34'bx;
      check(tag, {rresp, rdata}, e);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) model[i] = '0;
    // Reset state and release timing.
    tick(); tick();
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_regs", {reg0 | reg1 | reg2 | reg3}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("pre_edge_ready", {awready, wready, arready}, 3'b000);
    tick();
    check("post_edge_ready", {awready, wready, arready}, 3'b111);

    // Basic write then read back of all four registers.
    for (int i = 0; i < 4; i++) begin
      issue_write(6'(4 * i), 32'(i + 1), 4'hF);
      wait_b();
    end
    for (int i = 0; i < 4; i++) begin
      issue_read(6'(4 * i));
      wait_r("rd_basic");
    end
    check("reg3_basic", reg3, 32'h4);

    // W arrives three cycles ahead of AW.
    model_write(6'h08, 32'hDEADBEEF, 4'hF);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    check("w_early_ready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
    check("wready_drop", wready, 1'b0);
    tick(); tick(); tick();
    check("no_b_without_aw", bvalid, 1'b0);
    awaddr = 6'h08; awvalid = 1'b1;
    check("aw_late_ready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    check("b_one_cycle", bvalid, 1'b1);
    check("reg2_deadbeef", reg2, 32'hDEADBEEF);
    wait_b();

    // Byte strobes.
    issue_write(6'h04, 32'hFFFFFFFF, 4'hF); wait_b();
    issue_write(6'h04, 32'h12345678, 4'b0101); wait_b();
    check("reg1_strb", reg1, 32'hFF34FF78);
    check("reg1_model", reg1, model[1]);
    issue_write(6'h04, 32'h00000000, 4'b0000); wait_b();
    check("reg1_strb0", reg1, 32'hFF34FF78);

    // Write response backpressure.
    issue_write(6'h00, 32'hA5A5A5A5, 4'hF);
    for (int c = 0; c < 10; c++) begin
      check("b_hold", {bvalid, awready, wready}, 3'b100);
      tick();
    end
    wait_b();
    issue_write(6'h00, 32'h5A5A5A5A, 4'hF); wait_b();
    check("reg0_after_bp", reg0, 32'h5A5A5A5A);

    // Unmapped index.
    issue_read(6'h20); wait_r("rd_unmapped");
    issue_write(6'h20, 32'hCAFEF00D, 4'hF); wait_b();
    check("regs_unchanged", {reg0, reg1, reg2, reg3}, {model[0], model[1], model[2], model[3]});

    // Read and write of the same register on the same edge: the read sees the old value.
    model_read(6'h0C);
    model_write(6'h0C, 32'h0BADCAFE, 4'hF);
    awaddr = 6'h0C; wdata = 32'h0BADCAFE; wstrb = 4'hF; araddr = 6'h0C;
    check("concurrent_ready", {awready, wready, arready}, 3'b111);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_b();
    wait_r("rd_prewrite");
    check("reg3_postwrite", reg3, 32'h0BADCAFE);

    // Reset while both responses are pending.
    issue_write(6'h00, 32'h11111111, 4'hF);
    issue_read(6'h00);
    tick();
    check("pending_valids", {bvalid, rvalid}, 2'b11);
    check("rdata_stable", {rresp, rdata}, exp_r_q[0]);
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", {bvalid, rvalid}, 2'b00);
    check("rst_drop_ready", {awready, wready, arready}, 3'b000);
    check("rst_clear_regs", {reg0, reg1, reg2, reg3}, 128'h0);
    exp_b_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < 4; i++) model[i] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      issue_read(6'(4 * i));
      wait_r("rd_after_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/merge_ctrl_axil_slave.md
MERGE_CTRL_AXIL_SLAVE -- requirements
Module: merge_ctrl_axil_slave

Interface
REQ-001 The block SHALL provide parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL provide parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width; 16 word slots, 4 mapped.
REQ-003 The block SHALL have port S_AXI_ACLK, input, 1, sole clock.
REQ-004 The block SHALL have port S_AXI_ARESETN, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have write-address ports: S_AXI_AWADDR in [ADDR_W-1:0]; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 The block SHALL have write-data ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 The block SHALL have write-response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 The block SHALL have read-address ports: S_AXI_ARADDR in [ADDR_W-1:0]; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 The block SHALL have read-data ports: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 The block SHALL have ports reg0_o..reg3_o, out, 32 each, live register contents for the merge core.

Function
REQ-011 Register index SHALL be ADDR[ADDR_W-1:2]; indices 0..3 map to reg0..reg3, all read/write; ADDR[1:0] is ignored.
REQ-012 Write FSM SHALL have states W_IDLE, W_RESP; AW and W SHALL be accepted independently, each into a one-entry holding register.
REQ-013 AWREADY SHALL be high in W_IDLE when no address is held; WREADY SHALL be high in W_IDLE when no data is held; both low in W_RESP.
REQ-014 In the cycle both address and data are held (or handshake on the same edge), the register SHALL update at the next edge, per-byte by WSTRB; FSM enters W_RESP and BVALID rises on that same edge.
REQ-015 Minimum write latency SHALL be 1 cycle from the AW/W handshake edge to BVALID high; BVALID SHALL hold until BREADY, then return to W_IDLE and clear both holding registers.
REQ-016 Write with WSTRB=0 SHALL leave the register unchanged and still return a response.
REQ-017 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY high only in R_IDLE.
REQ-018 On AR handshake, RDATA/RRESP SHALL be registered and RVALID high at the next edge; RDATA and RRESP SHALL remain stable until RREADY, then return to R_IDLE.
REQ-019 Read and write channels SHALL operate concurrently; a read whose AR handshake occurs on the edge a write updates the same register SHALL return the pre-write value.
REQ-020 BRESP/RRESP SHALL be OKAY (2'b00) for mapped indices.

Reset
REQ-021 Asserting S_AXI_ARESETN low SHALL immediately clear reg0..reg3 to 0, all VALID/READY outputs to 0, BRESP/RRESP/RDATA to 0, and both FSMs to IDLE, discarding held AW/W and any pending response.
REQ-022 After deassertion, AWREADY, WREADY and ARREADY SHALL rise at the first clock edge.

Configuration
REQ-023 With macro MERGE_AXIL_SLVERR_EN defined, accesses to unmapped indices 4..15 SHALL return SLVERR (2'b10); reads return 0 and writes leave all registers unchanged.
REQ-024 Without MERGE_AXIL_SLVERR_EN, unmapped accesses SHALL return OKAY; reads return 0 and writes are discarded.

Verification
REQ-025 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all responses OKAY.
REQ-026 W presented 3 cycles before AW to 0x8, data 0xDEADBEEF -> WREADY drops after handshake; BVALID one cycle after AW handshake; reg2_o=0xDEADBEEF.
REQ-027 reg1=0xFFFFFFFF, write 0x12345678 WSTRB=4'b0101 -> reg1_o=0xFF34FF78.
REQ-028 BREADY held low 10 cycles -> BVALID stays high, AWREADY/WREADY low; next write accepted only after B handshake.
REQ-029 Read 0x20 -> RDATA 0; RRESP 2'b10 with MERGE_AXIL_SLVERR_EN, 2'b00 without; registers unchanged after write to 0x20.
REQ-030 Assert reset while BVALID and RVALID high -> both drop immediately, reg0..reg3 read 0 after release.
